// File: rtl/id_stage.sv
// Decode stage: register file, opcode decode and ID/EX pipeline register with load-use stall.
// Latency: one cycle from IF_ID_instr to the ID_EX_* outputs; the register file reads write-first.
// Backpressure: stall goes high for one cycle on a load-use hazard, and ID/EX takes a control bubble.
module id_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IF_ID_instr,
  input  logic [7:0]  IF_ID_NPC,
  input  logic        MEM_WB_RegWrite,
  input  logic [4:0]  MEM_WB_WriteReg,
  input  logic [31:0] MEM_WB_WriteData,
  output logic [1:0]  ID_EX_WB,
  output logic [2:0]  ID_EX_M,
  output logic [3:0]  ID_EX_EX,
  output logic [7:0]  ID_EX_NPC,
  output logic [31:0] ID_EX_rd1,
  output logic [31:0] ID_EX_rd2,
  output logic [31:0] ID_EX_imm,
  output logic [4:0]  ID_EX_rt,
  output logic [4:0]  ID_EX_rd,
  output logic        stall
);

  typedef struct packed {
    logic [1:0] wb;  // {RegWrite, MemtoReg}
    logic [2:0] m;   // {Branch, MemRead, MemWrite}
    logic [3:0] ex;  // {RegDst, ALUOp[1:0], ALUSrc}
  } ctl_t;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  ctl_t        ctl_dec;
  ctl_t        ctl_q, ctl_d;
  logic [7:0]  npc_q, npc_d;
  logic [31:0] rd1_q, rd1_d;
  logic [31:0] rd2_q, rd2_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  rd_q, rd_d;

  logic [4:0]  rs_idx, rt_idx;
  logic        wr_en;

  assign rs_idx = IF_ID_instr[25:21];
  assign rt_idx = IF_ID_instr[20:16];
  // A write to r0 is dropped here, so r0 is never updated and always reads zero.
  assign wr_en  = MEM_WB_RegWrite && (MEM_WB_WriteReg != 5'd0);

  // Register file next state: apply the writeback when it targets a nonzero register.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[MEM_WB_WriteReg] = MEM_WB_WriteData;
  end

  // Decode the opcode into the WB/M/EX control groups; unknown opcodes produce all-zero controls.
  always_comb begin
    ctl_dec = '0;
    unique case (IF_ID_instr[31:26])
      6'h00:   ctl_dec = '{wb: 2'b10, m: 3'b000, ex: 4'b1100};
      6'h23:   ctl_dec = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
      6'h2B:   ctl_dec = '{wb: 2'b00, m: 3'b001, ex: 4'b0001};
      6'h04:   ctl_dec = '{wb: 2'b00, m: 3'b100, ex: 4'b0010};
      default: ctl_dec = '0;
    endcase
  end

  // Load-use hazard: the load now in EX targets a register this instruction reads.
  always_comb begin
    stall = ctl_q.m[1] && (rt_q != 5'd0) && ((rt_q == rs_idx) || (rt_q == rt_idx));
  end

  // ID/EX next state. Reads are write-first so a same-cycle writeback is visible, and a stall inserts a control bubble.
  always_comb begin
    ctl_d = stall ? '0 : ctl_dec;
    npc_d = IF_ID_NPC;
    rd1_d = (rs_idx == 5'd0) ? 32'd0 :
            (wr_en && (MEM_WB_WriteReg == rs_idx)) ? MEM_WB_WriteData : regs_q[rs_idx];
    rd2_d = (rt_idx == 5'd0) ? 32'd0 :
            (wr_en && (MEM_WB_WriteReg == rt_idx)) ? MEM_WB_WriteData : regs_q[rt_idx];
    imm_d = {{16{IF_ID_instr[15]}}, IF_ID_instr[15:0]};
    rt_d  = rt_idx;
    rd_d  = IF_ID_instr[15:11];
  end

  // Register file and ID/EX pipeline register; reset clears everything and drops that edge's writeback.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
      ctl_q <= '0;
      npc_q <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
      imm_q <= '0;
      rt_q  <= '0;
      rd_q  <= '0;
    end else begin
      regs_q <= regs_d;
      ctl_q  <= ctl_d;
      npc_q  <= npc_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
    end
  end

  assign ID_EX_WB  = ctl_q.wb;
  assign ID_EX_M   = ctl_q.m;
  assign ID_EX_EX  = ctl_q.ex;
  assign ID_EX_NPC = npc_q;
  assign ID_EX_rd1 = rd1_q;
  assign ID_EX_rd2 = rd2_q;
  assign ID_EX_imm = imm_q;
  assign ID_EX_rt  = rt_q;
  assign ID_EX_rd  = rd_q;

endmodule
